// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIDDEN = 2'd1,
    UP     = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam int unsigned NUM_HOLES = 5;
  localparam logic [2:0]  HOLE_MIN  = 3'd1;
  localparam logic [2:0]  HOLE_MAX  = 3'd5;

endpackage

// File: rtl/mole_spawner_if.sv
// Game-control bus between the button/start front-end and the mole spawner.
interface mole_spawner_if
  import mole_pkg::*;
#(
  parameter int unsigned SCORE_W = 8
) ();

  logic                 start;
  logic [NUM_HOLES-1:0] hit_btn;
  logic [2:0]           oval_select;
  logic                 mole_visible;
  logic [SCORE_W-1:0]   score;
  logic [1:0]           miss_count;
  logic                 hit_pulse;
  logic                 game_active;

  // Front-end / display side
  modport master (
    output start, hit_btn,
    input  oval_select, mole_visible, score, miss_count, hit_pulse, game_active
  );

  // Spawner side
  modport slave (
    input  start, hit_btn,
    output oval_select, mole_visible, score, miss_count, hit_pulse, game_active
  );

endinterface

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
module mole_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] lfsr
);

  // An all-zero state would lock the register, so a zero seed becomes 1.
  localparam logic [7:0] SEED_SAFE = (SEED == 8'h00) ? 8'h01 : SEED;

  // Shift left, feeding back taps 8,6,5,4 into bit 0 every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= SEED_SAFE;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

endmodule

// File: rtl/mole_spawner.sv
// Mole scheduling, hole selection and score/miss bookkeeping.
module mole_spawner
  import mole_pkg::*;
#(
  parameter int unsigned UP_CYCLES   = 50_000_000,
  parameter int unsigned DOWN_CYCLES = 25_000_000,
  parameter int unsigned MAX_MISSES  = 3,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic           clk,
  input  logic           reset,
  mole_spawner_if.slave  bus
);

  localparam int unsigned MAX_CYC = (UP_CYCLES > DOWN_CYCLES) ? UP_CYCLES : DOWN_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] UP_LOAD   = CW'(UP_CYCLES);
  localparam logic [CW-1:0] DOWN_LOAD = CW'(DOWN_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);
  localparam logic [2:0]    MISS_END  = 3'(MAX_MISSES);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         oval_select;
  logic               mole_visible;
  logic [SCORE_W-1:0] score;
  logic [1:0]         miss_count;
  logic               hit_pulse;
  logic               game_active;
  logic [7:0]         lfsr;
  logic               hole_hit;
  logic [2:0]         miss_next;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  // Map the low three LFSR bits onto 1..5, stepping past the previous hole.
  function automatic logic [2:0] next_hole(input logic [7:0] r, input logic [2:0] prev);
    logic [2:0] h;
    h = (r[2:0] < 3'd5) ? r[2:0] + 3'd1 : r[2:0] - 3'd4;
    if (h == prev) begin
      h = (h == HOLE_MAX) ? HOLE_MIN : h + 3'd1;
    end
    return h;
  endfunction

  assign hole_hit  = bus.hit_btn[oval_select - HOLE_MIN];
  assign miss_next = {1'b0, miss_count} + 3'd1;

  // Game FSM: all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      oval_select  <= HOLE_MIN;
      mole_visible <= 1'b0;
      score        <= '0;
      miss_count   <= '0;
      hit_pulse    <= 1'b0;
      game_active  <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (bus.start) begin
            score       <= '0;
            miss_count  <= '0;
            cnt         <= DOWN_LOAD;
            game_active <= 1'b1;
            state       <= HIDDEN;
          end
        end
        HIDDEN: begin
          if (cnt == CNT_LAST) begin
            oval_select  <= next_hole(lfsr, oval_select);
            mole_visible <= 1'b1;
            cnt          <= UP_LOAD;
            state        <= UP;
          end else begin
            cnt <= cnt - CNT_LAST;
          end
        end
        UP: begin
          // A hit takes priority over a timeout landing on the same cycle.
          if (hole_hit) begin
            if (score != '1) begin
              score <= score + 1'b1;
            end
            hit_pulse    <= 1'b1;
            mole_visible <= 1'b0;
            cnt          <= DOWN_LOAD;
            state        <= HIDDEN;
          end else if (cnt == CNT_LAST) begin
            miss_count   <= miss_next[1:0];
            mole_visible <= 1'b0;
            if (miss_next == MISS_END) begin
              game_active <= 1'b0;
              state       <= OVER;
            end else begin
              cnt   <= DOWN_LOAD;
              state <= HIDDEN;
            end
          end else begin
            cnt <= cnt - CNT_LAST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oval_select  = oval_select;
  assign bus.mole_visible = mole_visible;
  assign bus.score        = score;
  assign bus.miss_count   = miss_count;
  assign bus.hit_pulse    = hit_pulse;
  assign bus.game_active  = game_active;

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner: two instances (8-bit and 4-bit score)
// share stimulus; hole choice is predicted from an independent LFSR model.
module tb_mole_spawner;
  import mole_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mole_spawner_if #(.SCORE_W(8)) bus8 ();
  mole_spawner_if #(.SCORE_W(4)) bus4 ();

  assign bus4.start   = bus8.start;
  assign bus4.hit_btn = bus8.hit_btn;

  mole_spawner #(
    .UP_CYCLES(8), .DOWN_CYCLES(4), .MAX_MISSES(3), .LFSR_SEED(8'hA5), .SCORE_W(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  mole_spawner #(
    .UP_CYCLES(8), .DOWN_CYCLES(4), .MAX_MISSES(3), .LFSR_SEED(8'hA5), .SCORE_W(4)
  ) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference LFSR; m_prev is the value the DUT consumed at the latest edge.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  end

  logic [2:0] prev_hole;
  int unsigned sb8[$];
  int unsigned sb4[$];
  int unsigned hits;

  function automatic logic [2:0] pick_hole(input logic [7:0] r, input logic [2:0] prev);
    int unsigned h;
    h = (32'(r[2:0]) % 5) + 1;
    if (h == 32'(prev)) h = (h % 5) + 1;
    return 3'(h);
  endfunction

  task automatic do_reset();
    bus8.start   = 1'b0;
    bus8.hit_btn = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    prev_hole = 3'd1;
    sb8.delete();
    sb4.delete();
    hits = 0;
  endtask

  // Bounded wait for the mole to rise; returns cycles waited.
  task automatic wait_up(output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (bus8.mole_visible === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL wait_up: mole_visible=%b after %0d cycles, required 1", bus8.mole_visible, cyc);
    end
  endtask

  task automatic test_reset();
    logic [21:0] obs, exp;
    do_reset();
    exp = {3'd1, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 4'd0, 2'(IDLE)};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      obs = {bus8.oval_select, bus8.mole_visible, bus8.score, bus8.miss_count,
             bus8.hit_pulse, bus8.game_active, bus4.score, 2'(dut.state)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: got %h required %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_no_hits();
    logic [11:0] obs, exp;
    logic [2:0]  e;
    bit vis, act;
    int unsigned miss;
    do_reset();
    bus8.start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      vis  = (k >= 5 && k <= 12) || (k >= 17 && k <= 24) || (k >= 29 && k <= 36);
      miss = (k <= 12) ? 0 : (k <= 24) ? 1 : (k <= 36) ? 2 : 3;
      act  = (k <= 36);
      exp  = {vis, 2'(miss), act, 8'd0};
      obs  = {bus8.mole_visible, bus8.miss_count, bus8.game_active, bus8.score};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL no_hits cyc%0d {vis,miss,act,score}: got %h required %h", k, obs, exp);
      end
      if (k == 5 || k == 17 || k == 29) begin
        e = pick_hole(m_prev, prev_hole);
        prev_hole = e;
        n_cmp++;
        if (bus8.oval_select !== e) begin
          n_bad++;
          $display("FAIL no_hits spawn cyc%0d oval: got %0d required %0d", k, bus8.oval_select, e);
        end
      end
      if (k == 37) begin
        n_cmp++;
        if (dut.state !== OVER) begin
          n_bad++;
          $display("FAIL no_hits over_state: got %0d required %0d", dut.state, OVER);
        end
      end
    end
  endtask

  task automatic test_hit();
    bit seen;
    int cyc;
    logic [2:0] e;
    int unsigned s;
    do_reset();
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_up(seen, cyc);
    n_cmp++;
    if (cyc != 4) begin
      n_bad++;
      $display("FAIL hit hidden_len: got %0d required 4", cyc);
    end
    e = pick_hole(m_prev, prev_hole);
    prev_hole = e;
    n_cmp++;
    if (bus8.oval_select !== e) begin
      n_bad++;
      $display("FAIL hit spawn oval: got %0d required %0d", bus8.oval_select, e);
    end
    repeat (2) @(negedge clk);
    bus8.hit_btn = 5'(5'd1 << (e - 3'd1));
    sb8.push_back(1);
    @(negedge clk);
    bus8.hit_btn = '0;
    s = sb8.pop_front();
    n_cmp++;
    if ({bus8.hit_pulse, bus8.mole_visible, bus8.score} !== {1'b1, 1'b0, 8'(s)}) begin
      n_bad++;
      $display("FAIL hit result {pulse,vis,score}: got %b,%b,%0d required 1,0,%0d",
               bus8.hit_pulse, bus8.mole_visible, bus8.score, s);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus8.hit_pulse, bus8.score} !== {1'b0, 8'd1}) begin
      n_bad++;
      $display("FAIL hit pulse_width {pulse,score}: got %b,%0d required 0,1", bus8.hit_pulse, bus8.score);
    end
    for (int k = 10; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus8.mole_visible !== (k == 12)) begin
        n_bad++;
        $display("FAIL hit respawn cyc%0d vis: got %b required %b", k, bus8.mole_visible, (k == 12));
      end
    end
    e = pick_hole(m_prev, prev_hole);
    prev_hole = e;
    n_cmp++;
    if (bus8.oval_select !== e) begin
      n_bad++;
      $display("FAIL hit respawn oval: got %0d required %0d", bus8.oval_select, e);
    end
  endtask

  task automatic test_wrong_then_last();
    bit seen;
    int cyc;
    logic [2:0] e;
    logic [4:0] oh;
    do_reset();
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_up(seen, cyc);
    e = pick_hole(m_prev, prev_hole);
    prev_hole = e;
    n_cmp++;
    if (bus8.oval_select !== e) begin
      n_bad++;
      $display("FAIL wrong spawn oval: got %0d required %0d", bus8.oval_select, e);
    end
    oh = 5'(5'd1 << (e - 3'd1));
    bus8.hit_btn = ~oh;
    @(negedge clk);
    bus8.hit_btn = '0;
    n_cmp++;
    if ({bus8.mole_visible, bus8.hit_pulse, bus8.score} !== {1'b1, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL wrong_press {vis,pulse,score}: got %b,%b,%0d required 1,0,0",
               bus8.mole_visible, bus8.hit_pulse, bus8.score);
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (bus8.mole_visible !== 1'b1) begin
      n_bad++;
      $display("FAIL last_up_cycle vis: got %b required 1", bus8.mole_visible);
    end
    bus8.hit_btn = oh;
    sb8.push_back(1);
    @(negedge clk);
    bus8.hit_btn = '0;
    n_cmp++;
    if ({bus8.hit_pulse, bus8.mole_visible, bus8.miss_count, bus8.score} !==
        {1'b1, 1'b0, 2'd0, 8'(sb8.pop_front())}) begin
      n_bad++;
      $display("FAIL last_cycle_hit {pulse,vis,miss,score}: got %b,%b,%0d,%0d required 1,0,0,1",
               bus8.hit_pulse, bus8.mole_visible, bus8.miss_count, bus8.score);
    end
  endtask

  task automatic test_reset_mid_up();
    bit seen;
    int cyc;
    logic [2:0] e;
    do_reset();
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_up(seen, cyc);
    e = pick_hole(m_prev, prev_hole);
    prev_hole = e;
    bus8.hit_btn = 5'(5'd1 << (e - 3'd1));
    @(negedge clk);
    bus8.hit_btn = '0;
    wait_up(seen, cyc);
    e = pick_hole(m_prev, prev_hole);
    prev_hole = e;
    n_cmp++;
    if (bus8.oval_select !== e) begin
      n_bad++;
      $display("FAIL midup spawn oval: got %0d required %0d", bus8.oval_select, e);
    end
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    n_cmp++;
    if ({bus8.mole_visible, bus8.game_active, bus8.score} !== {1'b1, 1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL start_ignored {vis,act,score}: got %b,%b,%0d required 1,1,1",
               bus8.mole_visible, bus8.game_active, bus8.score);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus8.mole_visible, bus8.game_active, bus8.score, bus8.oval_select, 2'(dut.state)} !==
        {1'b0, 1'b0, 8'd0, 3'd1, 2'(IDLE)}) begin
      n_bad++;
      $display("FAIL async_reset {vis,act,score,oval,state}: got %b,%b,%0d,%0d,%0d required 0,0,0,1,0",
               bus8.mole_visible, bus8.game_active, bus8.score, bus8.oval_select, dut.state);
    end
  endtask

  task automatic test_stress();
    bit seen;
    int cyc;
    logic [2:0] e, last_obs;
    logic [4:0] oh;
    int unsigned r, s8, s4;
    do_reset();
    last_obs = 3'd0;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      wait_up(seen, cyc);
      if (!seen) break;
      e = pick_hole(m_prev, prev_hole);
      prev_hole = e;
      n_cmp++;
      if (bus8.oval_select !== e || bus8.oval_select < 3'd1 || bus8.oval_select > 3'd5 ||
          bus8.oval_select === last_obs) begin
        n_bad++;
        $display("FAIL stress spawn%0d oval: got %0d required %0d (previous %0d)",
                 i, bus8.oval_select, e, last_obs);
      end
      last_obs = bus8.oval_select;
      r = $urandom_range(1, 8);
      repeat (r - 1) @(negedge clk);
      oh = 5'(5'd1 << (e - 3'd1));
      bus8.hit_btn = oh | 5'($urandom_range(0, 31));
      hits++;
      sb8.push_back((hits > 255) ? 255 : hits);
      sb4.push_back((hits > 15) ? 15 : hits);
      @(negedge clk);
      bus8.hit_btn = '0;
      s8 = sb8.pop_front();
      s4 = sb4.pop_front();
      n_cmp++;
      if ({bus8.hit_pulse, bus8.mole_visible, bus8.score, bus4.score} !==
          {1'b1, 1'b0, 8'(s8), 4'(s4)}) begin
        n_bad++;
        $display("FAIL stress hit%0d {pulse,vis,score8,score4}: got %b,%b,%0d,%0d required 1,0,%0d,%0d",
                 i, bus8.hit_pulse, bus8.mole_visible, bus8.score, bus4.score, s8, s4);
      end
    end
    n_cmp++;
    if ({bus8.score, bus4.score, bus8.miss_count} !== {8'd200, 4'd15, 2'd0}) begin
      n_bad++;
      $display("FAIL stress final {score8,score4,miss}: got %0d,%0d,%0d required 200,15,0",
               bus8.score, bus4.score, bus8.miss_count);
    end
  endtask

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus8.start   = 1'b0;
    bus8.hit_btn = '0;
    test_reset();
    test_no_hits();
    test_hit();
    test_wrong_then_last();
    test_reset_mid_up();
    test_stress();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
